// File: rtl/sky130_fd_io__pad_power_seq.sv
// Pad-frame power sequencer: brings per-channel pad enables up in a fixed order,
// releases the holds one channel at a time, and tears everything down on request or supply loss.
module sky130_fd_io__pad_power_seq #(
  parameter int NCH  = 4,
  parameter int DLYW = 8
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            start,
  input  logic            pgood_vddio,
  input  logic            pgood_vdda,
  input  logic            pgood_vccd,
  input  logic [DLYW-1:0] dly,
  input  logic [NCH-1:0]  ch_en,
  output logic [NCH-1:0]  enable_h,
  output logic [NCH-1:0]  enable_vdda_h,
  output logic [NCH-1:0]  enable_vswitch_h,
  output logic [NCH-1:0]  enable_inp_h,
  output logic [NCH-1:0]  hld_h_n,
  output logic            busy,
  output logic            ready,
  output logic            fault
);

  typedef enum logic [3:0] {
    OFF, WAIT_PG, EN_H, EN_VDDA, EN_VSW, EN_INP, RELEASE, ON, DOWN, FAULT
  } state_t;

  state_t          state_q, state_d;
  logic [DLYW-1:0] cnt_q, cnt_d;
  logic [DLYW-1:0] dly_q, dly_d;
  logic [NCH-1:0]  mask_q, mask_d;
  logic [2:0]      step_q, step_d;
  logic [NCH-1:0]  en_h_q, en_h_d;
  logic [NCH-1:0]  en_vdda_q, en_vdda_d;
  logic [NCH-1:0]  en_vsw_q, en_vsw_d;
  logic [NCH-1:0]  en_inp_q, en_inp_d;
  logic [NCH-1:0]  hld_q, hld_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            fault_q, fault_d;

  logic            pg_ok;
  logic [NCH-1:0]  pending;
  logic [NCH-1:0]  low_bit;

  assign pg_ok   = pgood_vddio & pgood_vdda & pgood_vccd;
  // Masked channels not yet released; isolating the lowest one makes skipped channels free.
  assign pending = mask_q & ~hld_q;
  assign low_bit = pending & (~pending + NCH'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dly_d     = dly_q;
    mask_d    = mask_q;
    step_d    = step_q;
    en_h_d    = en_h_q;
    en_vdda_d = en_vdda_q;
    en_vsw_d  = en_vsw_q;
    en_inp_d  = en_inp_q;
    hld_d     = hld_q;
    busy_d    = (state_q != OFF) && (state_q != ON) && (state_q != FAULT);
    ready_d   = (state_q == ON);
    fault_d   = (state_q == FAULT);

    case (state_q)
      OFF: begin
        if (start) begin
          state_d = WAIT_PG;
          dly_d   = dly;
          mask_d  = ch_en;
        end
      end

      WAIT_PG: begin
        if (!start) begin
          state_d = DOWN;
          cnt_d   = '0;
          step_d  = '0;
        end else if (pg_ok) begin
          state_d = EN_H;
          cnt_d   = dly_q;
        end
      end

      EN_H, EN_VDDA, EN_VSW, EN_INP: begin
        if (state_q == EN_H)    en_h_d    = en_h_q    | mask_q;
        if (state_q == EN_VDDA) en_vdda_d = en_vdda_q | mask_q;
        if (state_q == EN_VSW)  en_vsw_d  = en_vsw_q  | mask_q;
        if (state_q == EN_INP)  en_inp_d  = en_inp_q  | mask_q;
        if (!pg_ok) begin
          state_d = FAULT;
          cnt_d   = '0;
          step_d  = '0;
        end else if (!start) begin
          state_d = DOWN;
          cnt_d   = '0;
          step_d  = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DLYW'(1);
        end else begin
          cnt_d = dly_q;
          case (state_q)
            EN_H:    state_d = EN_VDDA;
            EN_VDDA: state_d = EN_VSW;
            EN_VSW:  state_d = EN_INP;
            default: begin
              state_d = RELEASE;
              cnt_d   = '0;
            end
          endcase
        end
      end

      RELEASE: begin
        if (!pg_ok) begin
          state_d = FAULT;
          cnt_d   = '0;
          step_d  = '0;
        end else if (!start) begin
          state_d = DOWN;
          cnt_d   = '0;
          step_d  = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DLYW'(1);
        end else if (pending == '0) begin
          state_d = ON;
        end else begin
          hld_d = hld_q | low_bit;
          cnt_d = dly_q;
          if ((pending & ~low_bit) == '0) state_d = ON;
        end
      end

      ON: begin
        if (!pg_ok) begin
          state_d = FAULT;
          cnt_d   = '0;
          step_d  = '0;
        end else if (!start) begin
          state_d = DOWN;
          cnt_d   = '0;
          step_d  = '0;
        end
      end

      DOWN: begin
        if (!pg_ok) begin
          state_d = FAULT;
          cnt_d   = '0;
          step_d  = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DLYW'(1);
        end else begin
          // Holds go first, then enables in reverse of power-up order.
          cnt_d  = dly_q;
          step_d = step_q + 3'd1;
          case (step_q)
            3'd0: hld_d     = '0;
            3'd1: en_inp_d  = '0;
            3'd2: en_vsw_d  = '0;
            3'd3: en_vdda_d = '0;
            default: begin
              en_h_d  = '0;
              state_d = OFF;
              cnt_d   = '0;
              step_d  = '0;
            end
          endcase
        end
      end

      FAULT: begin
        en_h_d    = '0;
        en_vdda_d = '0;
        en_vsw_d  = '0;
        en_inp_d  = '0;
        hld_d     = '0;
        cnt_d     = '0;
        step_d    = '0;
        if (!start && pg_ok) state_d = OFF;
      end

      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= OFF;
      cnt_q     <= '0;
      dly_q     <= '0;
      mask_q    <= '0;
      step_q    <= '0;
      en_h_q    <= '0;
      en_vdda_q <= '0;
      en_vsw_q  <= '0;
      en_inp_q  <= '0;
      hld_q     <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dly_q     <= dly_d;
      mask_q    <= mask_d;
      step_q    <= step_d;
      en_h_q    <= en_h_d;
      en_vdda_q <= en_vdda_d;
      en_vsw_q  <= en_vsw_d;
      en_inp_q  <= en_inp_d;
      hld_q     <= hld_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign enable_h         = en_h_q;
  assign enable_vdda_h    = en_vdda_q;
  assign enable_vswitch_h = en_vsw_q;
  assign enable_inp_h     = en_inp_q;
  assign hld_h_n          = hld_q;
  assign busy             = busy_q;
  assign ready            = ready_q;
  assign fault            = fault_q;

endmodule

// File: doc/sky130_fd_io__pad_power_seq.md
SKY130_FD_IO__PAD_POWER_SEQ -- requirements
Module: sky130_fd_io__pad_power_seq

Interface
REQ-001 Parameter NCH, default 4, is the number of pad channels sequenced (1..32).
REQ-002 Parameter DLYW, default 8, is the width of the per-step dwell counter.
REQ-003 Port clock, input, 1: the single clock; all state changes occur on its rising edge.
REQ-004 Port resetn, input, 1: synchronous, active-low reset.
REQ-005 Port start, input, 1: level request to power the pad frame up; 0 requests power-down.
REQ-006 Ports pgood_vddio, pgood_vdda, pgood_vccd, input, 1 each: supply-good flags, active high.
REQ-007 Port dly, input, DLYW: step dwell value, sampled only at sequence start.
REQ-008 Port ch_en, input, NCH: channel participation mask, sampled only at sequence start.
REQ-009 Ports enable_h, enable_vdda_h, enable_vswitch_h, enable_inp_h, output, NCH each: per-channel pad enables.
REQ-010 Port hld_h_n, output, NCH: per-channel hold release; 0 = held.
REQ-011 Port busy, output, 1: sequence in progress.
REQ-012 Port ready, output, 1: all enabled channels released.
REQ-013 Port fault, output, 1: supply-loss latch.

Function
REQ-014 All outputs are registered; every output change is visible the cycle after the state or condition that causes it.
REQ-015 The FSM has the states OFF, WAIT_PG, EN_H, EN_VDDA, EN_VSW, EN_INP, RELEASE, ON, DOWN and FAULT.
REQ-016 OFF -> WAIT_PG when start=1; in that same cycle dly is latched to dly_q and ch_en to mask_q.
REQ-017 WAIT_PG -> EN_H when all three pgood flags are 1; otherwise the FSM waits indefinitely.
REQ-018 Each of EN_H, EN_VDDA, EN_VSW and EN_INP dwells exactly dly_q+1 cycles (dly_q=0 gives 1 cycle), then advances in the order listed.
REQ-019 On entry to each of those steps, the matching enable bit sets for every channel with mask_q=1 and stays set through ON.
REQ-020 Enable bits for channels with mask_q=0 remain 0 throughout.
REQ-021 RELEASE sets hld_h_n one masked channel at a time, in ascending index order, with dly_q+1 cycles between successive releases.
REQ-022 RELEASE skips channels with mask_q=0 at no cycle cost.
REQ-023 RELEASE -> ON after the highest-index masked channel is released.
REQ-024 If mask_q is all zero, RELEASE -> ON after one cycle.
REQ-025 In ON, ready=1; busy=1 in every state except OFF, ON and FAULT.
REQ-026 From ON, start=0 -> DOWN.
REQ-027 DOWN clears all hld_h_n on the first cycle, then clears enable_inp_h, enable_vswitch_h, enable_vdda_h and enable_h in that order, each dly_q+1 cycles apart, then enters OFF.
REQ-028 start=0 in WAIT_PG through RELEASE aborts the sequence into DOWN at its first cycle.
REQ-029 Any pgood=0 in EN_H through DOWN -> FAULT.
REQ-030 On the cycle after FAULT is entered, all hld_h_n are 0, all enables are 0, fault=1 and ready=0.
REQ-031 FAULT -> OFF only when start=0 and all pgood=1; fault clears on that transition.
REQ-032 The dwell counter is DLYW bits wide, counts down from dly_q to 0, and does not wrap; dly=all-ones gives 2^DLYW cycles.
REQ-033 A pgood drop in the same cycle as start=0 gives FAULT priority over DOWN.
REQ-034 A change of dly or ch_en outside the OFF->WAIT_PG edge has no effect.

Reset
REQ-035 While resetn=0 at a clock edge: state=OFF, all enables 0, hld_h_n all 0, busy=0, ready=0, fault=0, counters 0.
REQ-036 Reset asserted mid-sequence or in FAULT takes effect at the next edge and overrides all other conditions.

Verification
REQ-037 NCH=4, dly=2, ch_en=4'b1111, pgood all 1, start 0->1: enable_h at +2, enable_vdda_h +3 later, enable_vswitch_h +3, enable_inp_h +3; hld_h_n bits 0..3 set 3 cycles apart; ready=1 one cycle after bit 3.
REQ-038 ch_en=4'b1010, dly=0: enables only on bits 1 and 3; hld_h_n[1] then hld_h_n[3] on consecutive cycles; bits 0 and 2 stay 0.
REQ-039 pgood_vdda drops during RELEASE after bit 1 is released: next cycle all outputs 0 and fault=1; with start=0 and pgood restored, FSM -> OFF and fault=0.
REQ-040 From ON with dly=1: start=0 -> hld_h_n all 0, then enables drop inp, vswitch, vdda, h at 2-cycle spacing; busy=0 after OFF.
REQ-041 resetn=0 for one cycle during EN_VSW: all outputs 0 at the next edge; a fresh start with dly=0 completes normally.
REQ-042 dly=8'hFF, DLYW=8: EN_H dwell measures exactly 256 cycles.
